fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 143 ++++++++++++++
 tb/tb_fetch_unit.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch engine with a single IF/ID register.
// A three-state FSM (IDLE -> FETCH -> HALTED) issues word fetches. Each
// accepted ack loads the IF/ID register. Decode may redirect the PC, and
// a fetched HALT opcode stops the engine until reset.
//
// Handshake: imem_req is a request qualifier, not a held valid. An
// instruction is accepted in a cycle only when imem_req=1 and imem_ack=1
// are both high in that cycle. Any ack seen while imem_req=0 is ignored.
//
// Optional feature: define FETCH_PERF_CNT_EN to count accepted
// instructions on fetch_count. Without it, fetch_count is tied to 0.
module fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [5:0]  HALT_OPCODE = 6'h3F
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        ifid_valid,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  sa,
    output logic [5:0]  funct,
    output logic [25:0] instr_address,
    output logic [14:0] Adress_Immediate,
    output logic [1:0]  InstructionType,
    output logic [31:0] pc,
    output logic        halted,
    output logic [31:0] fetch_count,
    output logic [1:0]  fsm_state
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH  = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc_q;
    logic [31:0] ir_q;
    logic [31:0] ifid_pc_q;
    logic [1:0]  itype_q;
    logic        valid_q;
    logic        accept;
    logic        unused_redirect_lsbs;

    // Word alignment drops the two low bits of the redirect target.
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    function automatic logic [1:0] decode_type(input logic [5:0] op);
        if (op == 6'h00)                     decode_type = 2'd0;
        else if (op == 6'h02 || op == 6'h03) decode_type = 2'd1;
        else if (op == HALT_OPCODE)          decode_type = 2'd2;
        else                                 decode_type = 2'd3;
    endfunction

    assign accept = imem_req & imem_ack;

    // Next-state and request logic; a held instruction under stall or a
    // pending redirect suppresses the request.
    always_comb begin
        state_next = state;
        imem_req   = 1'b0;
        case (state)
            S_IDLE: state_next = S_FETCH;
            S_FETCH: begin
                imem_req = !(stall && valid_q) && !redirect_valid;
                if (imem_req && imem_ack && imem_rdata[31:26] == HALT_OPCODE)
                    state_next = S_HALTED;
            end
            S_HALTED: state_next = S_HALTED;
            default:  state_next = S_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // PC and IF/ID register: redirect beats ack, and ack beats stall/drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q      <= RESET_PC;
            ir_q      <= 32'h0;
            ifid_pc_q <= 32'h0;
            itype_q   <= 2'd0;
            valid_q   <= 1'b0;
        end else if (state == S_FETCH && redirect_valid) begin
            pc_q    <= {redirect_pc[31:2], 2'b00};
            valid_q <= 1'b0;
        end else if (accept) begin
            ir_q      <= imem_rdata;
            ifid_pc_q <= pc_q;
            itype_q   <= decode_type(imem_rdata[31:26]);
            valid_q   <= 1'b1;
            pc_q      <= pc_q + 32'd4;
        end else if (!stall) begin
            valid_q <= 1'b0;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] count_q;

    // Count accepted instructions; the counter wraps naturally at 2^32.
    always_ff @(posedge clk) begin
        if (rst)         count_q <= 32'h0;
        else if (accept) count_q <= count_q + 32'd1;
    end

    assign fetch_count = count_q;
`else
    assign fetch_count = 32'h0;
`endif

    assign imem_addr        = pc_q;
    assign ifid_valid       = valid_q;
    assign opcode           = ir_q[31:26];
    assign rs               = ir_q[25:21];
    assign rt               = ir_q[20:16];
    assign rd               = ir_q[15:11];
    assign sa               = ir_q[10:6];
    assign funct            = ir_q[5:0];
    assign instr_address    = ir_q[25:0];
    assign Adress_Immediate = ir_q[14:0];
    assign InstructionType  = itype_q;
    assign pc               = ifid_pc_q;
    assign halted           = (state == S_HALTED);
    assign fsm_state        = state;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: table-driven check of fetch_unit.
// The first instance uses the default RESET_PC. A second instance starts
// at 32'hFFFF_FFFC to exercise PC wrap.
module tb_fetch_unit;

`ifdef FETCH_PERF_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req, imem_ack, stall, redirect_valid, ifid_valid, halted;
    logic [31:0] imem_addr, imem_rdata, redirect_pc, pc, fetch_count;
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, sa;
    logic [25:0] instr_address;
    logic [14:0] Adress_Immediate;
    logic [1:0]  InstructionType, fsm_state;

    logic        imem_req2, imem_ack2, stall2, redirect_valid2, ifid_valid2, halted2;
    logic [31:0] imem_addr2, imem_rdata2, redirect_pc2, pc2, fetch_count2;
    logic [5:0]  opcode2, funct2;
    logic [4:0]  rs2, rt2, rd2, sa2;
    logic [25:0] instr_address2;
    logic [14:0] Adress_Immediate2;
    logic [1:0]  InstructionType2, fsm_state2;

    int checks = 0;
    int errors = 0;

    fetch_unit dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_ack(imem_ack), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .ifid_valid(ifid_valid), .opcode(opcode), .rs(rs), .rt(rt), .rd(rd),
        .sa(sa), .funct(funct), .instr_address(instr_address),
        .Adress_Immediate(Adress_Immediate), .InstructionType(InstructionType),
        .pc(pc), .halted(halted), .fetch_count(fetch_count), .fsm_state(fsm_state)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst(rst), .imem_req(imem_req2), .imem_addr(imem_addr2),
        .imem_rdata(imem_rdata2), .imem_ack(imem_ack2), .stall(stall2),
        .redirect_valid(redirect_valid2), .redirect_pc(redirect_pc2),
        .ifid_valid(ifid_valid2), .opcode(opcode2), .rs(rs2), .rt(rt2), .rd(rd2),
        .sa(sa2), .funct(funct2), .instr_address(instr_address2),
        .Adress_Immediate(Adress_Immediate2), .InstructionType(InstructionType2),
        .pc(pc2), .halted(halted2), .fetch_count(fetch_count2), .fsm_state(fsm_state2)
    );

    // Clock.
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic        ack;
        logic [31:0] rdata;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc;
        logic [31:0] ir;
        logic [1:0]  typ;
        logic        halted;
    } vec_t;

    vec_t vecs[15];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_fields(input string tag, input logic [31:0] w);
        check({tag, " fields"}, {opcode, rs, rt, rd, sa, funct}, w);
        check({tag, " instr_address"}, {6'h0, instr_address}, {6'h0, w[25:0]});
        check({tag, " imm"}, {17'h0, Adress_Immediate}, {17'h0, w[14:0]});
    endtask

    initial begin
        //            stall redir rpc           ack rdata          req addr           valid pc             ir             typ halted
        vecs[0]  = '{1'b0, 1'b0, 32'h0,       1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 32'h0000_0000, 2'd0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 32'h0,       1'b1, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 32'h0000_0000, 32'h0000_0000, 2'd0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 32'h0,       1'b1, 32'h2022_0005, 1'b1, 32'h0000_0004, 1'b1, 32'h0000_0004, 32'h2022_0005, 2'd3, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 32'h0,       1'b1, 32'h0800_0040, 1'b1, 32'h0000_0008, 1'b1, 32'h0000_0008, 32'h0800_0040, 2'd1, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 32'h0,       1'b1, 32'h1111_1111, 1'b0, 32'h0000_000C, 1'b1, 32'h0000_0008, 32'h0800_0040, 2'd1, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 32'h0,       1'b1, 32'h1111_1111, 1'b0, 32'h0000_000C, 1'b1, 32'h0000_0008, 32'h0800_0040, 2'd1, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 32'h0,       1'b1, 32'h1111_1111, 1'b0, 32'h0000_000C, 1'b1, 32'h0000_0008, 32'h0800_0040, 2'd1, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 32'h0,       1'b0, 32'h2222_2222, 1'b1, 32'h0000_000C, 1'b0, 32'h0000_0008, 32'h0800_0040, 2'd1, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 32'h0,       1'b1, 32'h0C00_0000, 1'b1, 32'h0000_000C, 1'b1, 32'h0000_000C, 32'h0C00_0000, 2'd1, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 32'h103,     1'b1, 32'h1234_5678, 1'b0, 32'h0000_0010, 1'b0, 32'h0000_000C, 32'h0C00_0000, 2'd1, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 32'h0,       1'b1, 32'h8C22_0010, 1'b1, 32'h0000_0100, 1'b1, 32'h0000_0100, 32'h8C22_0010, 2'd3, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 32'h207,     1'b1, 32'h3333_3333, 1'b0, 32'h0000_0104, 1'b0, 32'h0000_0100, 32'h8C22_0010, 2'd3, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 32'h0,       1'b1, 32'hFC00_0000, 1'b1, 32'h0000_0204, 1'b1, 32'h0000_0204, 32'hFC00_0000, 2'd2, 1'b1};
        vecs[13] = '{1'b0, 1'b1, 32'h40,      1'b1, 32'h0000_0001, 1'b0, 32'h0000_0208, 1'b0, 32'h0000_0204, 32'hFC00_0000, 2'd2, 1'b1};
        vecs[14] = '{1'b0, 1'b0, 32'h0,       1'b1, 32'h0000_0001, 1'b0, 32'h0000_0208, 1'b0, 32'h0000_0204, 32'hFC00_0000, 2'd2, 1'b1};

        rst = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0; stall = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 32'h0;
        imem_ack2 = 1'b1; imem_rdata2 = 32'h0; stall2 = 1'b0;
        redirect_valid2 = 1'b0; redirect_pc2 = 32'h0;

        // Reset state.
        tick();
        rst = 1'b0;
        #1;
        check("reset valid", {31'h0, ifid_valid}, 32'h0);
        check("reset halted", {31'h0, halted}, 32'h0);
        check("reset req", {31'h0, imem_req}, 32'h0);
        check("reset addr", imem_addr, 32'h0);
        check("reset pc", pc, 32'h0);
        check("reset count", fetch_count, 32'h0);
        check_fields("reset", 32'h0);

        // Main table: fetch stream, stall, redirect, halt.
        for (int i = 0; i < 15; i++) begin
            stall          = vecs[i].stall;
            redirect_valid = vecs[i].redir;
            redirect_pc    = vecs[i].rpc;
            imem_ack       = vecs[i].ack;
            imem_rdata     = vecs[i].rdata;
            #1;
            check($sformatf("v%0d req", i), {31'h0, imem_req}, {31'h0, vecs[i].req});
            check($sformatf("v%0d addr", i), imem_addr, vecs[i].addr);
            tick();
            check($sformatf("v%0d valid", i), {31'h0, ifid_valid}, {31'h0, vecs[i].valid});
            check($sformatf("v%0d pc", i), pc, vecs[i].pc);
            check($sformatf("v%0d type", i), {30'h0, InstructionType}, {30'h0, vecs[i].typ});
            check($sformatf("v%0d halted", i), {31'h0, halted}, {31'h0, vecs[i].halted});
            check_fields($sformatf("v%0d", i), vecs[i].ir);
        end
        check("count after table", fetch_count, CNT_ON ? 32'd6 : 32'd0);

        // Wrap instance plus reset-in-mid-fetch on the main instance.
        imem_ack = 1'b0; stall = 1'b0; redirect_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("wrap idle addr", imem_addr2, 32'hFFFF_FFFC);
        check("wrap idle req", {31'h0, imem_req2}, 32'h0);
        tick();
        check("wrap first req", {31'h0, imem_req2}, 32'h1);
        check("wrap first addr", imem_addr2, 32'hFFFF_FFFC);
        imem_ack = 1'b1; imem_rdata = 32'h2022_0005;
        tick();
        check("wrap second addr", imem_addr2, 32'h0);
        check("wrap first pc", pc2, 32'hFFFF_FFFC);
        check("main first valid", {31'h0, ifid_valid}, 32'h1);
        tick();
        check("wrap second pc", pc2, 32'h0);
        check("wrap third addr", imem_addr2, 32'h4);
        check("wrap count", fetch_count2, CNT_ON ? 32'd2 : 32'd0);
        check("main count", fetch_count, CNT_ON ? 32'd2 : 32'd0);
        check("main mid addr", imem_addr, 32'h8);
        #1;
        check("main mid req", {31'h0, imem_req}, 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst mid valid", {31'h0, ifid_valid}, 32'h0);
        check("rst mid pc", pc, 32'h0);
        check("rst mid addr", imem_addr, 32'h0);
        check("rst mid count", fetch_count, 32'h0);
        check_fields("rst mid", 32'h0);
        check("rst wrap addr", imem_addr2, 32'hFFFF_FFFC);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
